// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Bundle of the two master request ports, the shared memory
//                port and the owner indication for mem_port_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if;
   // Master 0 (CPU load/store unit)
   logic        m0_req;
   logic        m0_lock;
   logic [31:0] m0_addr;
   logic [31:0] m0_wrdata;
   logic [2:0]  m0_memop;
   logic        m0_we;
   logic        m0_gnt;
   logic        m0_rvalid;
   logic [31:0] m0_rddata;
   // Master 1 (DMA / blit engine)
   logic        m1_req;
   logic        m1_lock;
   logic [31:0] m1_addr;
   logic [31:0] m1_wrdata;
   logic [2:0]  m1_memop;
   logic        m1_we;
   logic        m1_gnt;
   logic        m1_rvalid;
   logic [31:0] m1_rddata;
   // Shared memory port
   logic [31:0] mem_addr;
   logic [31:0] mem_wrdata;
   logic [2:0]  mem_memop;
   logic        mem_we;
   logic [31:0] mem_rddata;
   logic [1:0]  arb_owner;

   // Arbiter side
   modport slave (
      input  m0_req, m0_lock, m0_addr, m0_wrdata, m0_memop, m0_we,
      output m0_gnt, m0_rvalid, m0_rddata,
      input  m1_req, m1_lock, m1_addr, m1_wrdata, m1_memop, m1_we,
      output m1_gnt, m1_rvalid, m1_rddata,
      output mem_addr, mem_wrdata, mem_memop, mem_we, arb_owner,
      input  mem_rddata
   );

   // Requester / memory side
   modport master (
      output m0_req, m0_lock, m0_addr, m0_wrdata, m0_memop, m0_we,
      input  m0_gnt, m0_rvalid, m0_rddata,
      output m1_req, m1_lock, m1_addr, m1_wrdata, m1_memop, m1_we,
      input  m1_gnt, m1_rvalid, m1_rddata,
      input  mem_addr, mem_wrdata, mem_memop, mem_we, arb_owner,
      output mem_rddata
   );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Two-master fixed-priority arbiter for the memory_map data
//                port with anti-starvation hold limit, lock and read tagging.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
   parameter int MAX_HOLD   = 16,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mem_port_arbiter_if.slave     port_if
);

   localparam int HOLD_W = $clog2(MAX_HOLD + 1);

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_M0   = 2'b01,
      OWN_M1   = 2'b10
   } owner_e;

   owner_e                  lock_owner_q;
   owner_e                  lock_owner_d;
   owner_e                  winner;
   logic [HOLD_W-1:0]       hold_cnt_q;
   logic [HOLD_W-1:0]       hold_cnt_d;
   logic [RD_LATENCY-1:0]   rd_vld_q;
   logic [RD_LATENCY-1:0]   rd_vld_d;
   logic [RD_LATENCY-1:0]   rd_id_q;
   logic [RD_LATENCY-1:0]   rd_id_d;
   logic                    hold_full;
   logic                    win_we;
   logic                    rd_issue;

   assign hold_full = (hold_cnt_q == HOLD_W'(MAX_HOLD));

   // Winner selection; gating on rst_n keeps the port silent while reset is held.
   always_comb begin
      winner = OWN_NONE;
      if (!rst_n) begin
         winner = OWN_NONE;
      end else if ((lock_owner_q == OWN_M0) && port_if.m0_req) begin
         winner = OWN_M0;
      end else if ((lock_owner_q == OWN_M1) && port_if.m1_req) begin
         winner = OWN_M1;
      end else if (port_if.m1_req && hold_full) begin
         winner = OWN_M1;
      end else if (port_if.m0_req) begin
         winner = OWN_M0;
      end else if (port_if.m1_req) begin
         winner = OWN_M1;
      end
   end

   // Bus mux, grants and next-state
   always_comb begin
      port_if.m0_gnt     = 1'b0;
      port_if.m1_gnt     = 1'b0;
      port_if.mem_addr   = 32'h0;
      port_if.mem_wrdata = 32'h0;
      port_if.mem_memop  = 3'b000;
      win_we             = 1'b0;
      lock_owner_d       = OWN_NONE;
      hold_cnt_d         = '0;

      case (winner)
         OWN_M0: begin
            port_if.m0_gnt     = 1'b1;
            port_if.mem_addr   = port_if.m0_addr;
            port_if.mem_wrdata = port_if.m0_wrdata;
            port_if.mem_memop  = port_if.m0_memop;
            win_we             = port_if.m0_we;
            lock_owner_d       = port_if.m0_lock ? OWN_M0 : OWN_NONE;
         end
         OWN_M1: begin
            port_if.m1_gnt     = 1'b1;
            port_if.mem_addr   = port_if.m1_addr;
            port_if.mem_wrdata = port_if.m1_wrdata;
            port_if.mem_memop  = port_if.m1_memop;
            win_we             = port_if.m1_we;
            lock_owner_d       = port_if.m1_lock ? OWN_M1 : OWN_NONE;
         end
         default: begin
            lock_owner_d = OWN_NONE;
         end
      endcase

      // Counts M0 wins while M1 waits; saturates so a lock can outlast the limit.
      if ((winner == OWN_M0) && port_if.m1_req) begin
         hold_cnt_d = hold_full ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
      end
   end

   assign port_if.mem_we    = win_we & (winner != OWN_NONE);
   assign port_if.arb_owner = winner;

   // Read-return tag pipeline: bit 0 is the newest entry.
   assign rd_issue = (winner != OWN_NONE) & ~win_we;
   assign rd_vld_d = (rd_vld_q << 1) | RD_LATENCY'(rd_issue);
   assign rd_id_d  = (rd_id_q  << 1) | RD_LATENCY'(winner == OWN_M1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_owner_q <= OWN_NONE;
         hold_cnt_q   <= '0;
         rd_vld_q     <= '0;
         rd_id_q      <= '0;
      end else begin
         lock_owner_q <= lock_owner_d;
         hold_cnt_q   <= hold_cnt_d;
         rd_vld_q     <= rd_vld_d;
         rd_id_q      <= rd_id_d;
      end
   end

   assign port_if.m0_rvalid = rd_vld_q[RD_LATENCY-1] & ~rd_id_q[RD_LATENCY-1];
   assign port_if.m1_rvalid = rd_vld_q[RD_LATENCY-1] &  rd_id_q[RD_LATENCY-1];
   assign port_if.m0_rddata = port_if.mem_rddata;
   assign port_if.m1_rddata = port_if.mem_rddata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed self-checking bench for mem_port_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(
      .MAX_HOLD   (4),
      .RD_LATENCY (1)
   ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .port_if (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.m0_req = 1'b0; bus.m0_lock = 1'b0; bus.m0_addr = 32'h0;
      bus.m0_wrdata = 32'h0; bus.m0_memop = 3'd0; bus.m0_we = 1'b0;
      bus.m1_req = 1'b0; bus.m1_lock = 1'b0; bus.m1_addr = 32'h0;
      bus.m1_wrdata = 32'h0; bus.m1_memop = 3'd0; bus.m1_we = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      bus.mem_rddata = 32'h0;
      clear_inputs();

      // Held in reset with requests pending: port must stay silent
      bus.m0_req = 1'b1; bus.m1_req = 1'b1; bus.m1_we = 1'b1;
      @(negedge clk);
      check_val("rst_m0_gnt",    32'(bus.m0_gnt),    32'd0);
      check_val("rst_m1_gnt",    32'(bus.m1_gnt),    32'd0);
      check_val("rst_mem_we",    32'(bus.mem_we),    32'd0);
      check_val("rst_owner",     32'(bus.arb_owner), 32'd0);
      check_val("rst_m0_rvalid", 32'(bus.m0_rvalid), 32'd0);
      step();
      rst_n = 1'b1;
      clear_inputs();

      // 1: lone M0 read, data one cycle later
      bus.m0_req = 1'b1; bus.m0_addr = 32'h0010_0004; bus.m0_memop = 3'd2;
      @(negedge clk);
      check_val("t1_m0_gnt",   32'(bus.m0_gnt),    32'd1);
      check_val("t1_m1_gnt",   32'(bus.m1_gnt),    32'd0);
      check_val("t1_mem_we",   32'(bus.mem_we),    32'd0);
      check_val("t1_mem_addr", bus.mem_addr,       32'h0010_0004);
      check_val("t1_memop",    32'(bus.mem_memop), 32'd2);
      check_val("t1_owner",    32'(bus.arb_owner), 32'd1);
      step();
      clear_inputs();
      bus.mem_rddata = 32'hDEAD_BEEF;
      @(negedge clk);
      check_val("t1_m0_rvalid", 32'(bus.m0_rvalid), 32'd1);
      check_val("t1_m1_rvalid", 32'(bus.m1_rvalid), 32'd0);
      check_val("t1_m0_rddata", bus.m0_rddata,      32'hDEAD_BEEF);
      step();

      // 5: idle bus, then lone M1 write
      @(negedge clk);
      check_val("t5_idle_we",     32'(bus.mem_we),    32'd0);
      check_val("t5_idle_addr",   bus.mem_addr,       32'h0);
      check_val("t5_idle_wrdata", bus.mem_wrdata,     32'h0);
      check_val("t5_idle_owner",  32'(bus.arb_owner), 32'd0);
      check_val("t5_idle_rvalid", 32'(bus.m0_rvalid), 32'd0);
      step();
      bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h0020_0010;
      bus.m1_wrdata = 32'hCAFE_0001;
      @(negedge clk);
      check_val("t5_m1_we",     32'(bus.mem_we),    32'd1);
      check_val("t5_m1_gnt",    32'(bus.m1_gnt),    32'd1);
      check_val("t5_m1_wrdata", bus.mem_wrdata,     32'hCAFE_0001);
      check_val("t5_m1_owner",  32'(bus.arb_owner), 32'd2);
      step();
      clear_inputs();
      @(negedge clk);
      check_val("t5_wr_no_rvalid", 32'(bus.m1_rvalid), 32'd0);
      step();

      // 2: both masters every cycle, hold limit 4 forces M1 every 5th cycle
      bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m1_req = 1'b1; bus.m1_we = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_val($sformatf("t2_owner[%0d]", i), 32'(bus.arb_owner), (i % 5 == 4) ? 32'd2 : 32'd1);
         check_val($sformatf("t2_m0_gnt[%0d]", i), 32'(bus.m0_gnt), (i % 5 == 4) ? 32'd0 : 32'd1);
         step();
      end

      // Lock outlasts the hold limit; M1 wins on the first cycle after the lock drops
      bus.m0_lock = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i == 6) bus.m0_lock = 1'b0;
         @(negedge clk);
         check_val($sformatf("lk_owner[%0d]", i), 32'(bus.arb_owner), (i == 7) ? 32'd2 : 32'd1);
         step();
      end
      clear_inputs();

      // 3: M1 locked write burst keeps M0 out until the unlocked last beat
      for (int i = 0; i < 5; i++) begin
         bus.m1_req  = (i < 4);
         bus.m1_we   = 1'b1;
         bus.m1_lock = (i < 3);
         bus.m1_addr = 32'h0030_0000 + 32'(4 * i);
         bus.m0_req  = (i > 0);
         bus.m0_we   = 1'b1;
         bus.m0_addr = 32'h0000_0100;
         @(negedge clk);
         check_val($sformatf("t3_m0_gnt[%0d]", i), 32'(bus.m0_gnt), (i == 4) ? 32'd1 : 32'd0);
         check_val($sformatf("t3_addr[%0d]", i), bus.mem_addr,
                   (i == 4) ? 32'h0000_0100 : 32'h0030_0000 + 32'(4 * i));
         step();
      end
      clear_inputs();

      // 4: M0 read A, M1 read B, M0 write C, pipelined
      bus.m0_req = 1'b1; bus.m0_addr = 32'h0000_00A0;
      @(negedge clk);
      check_val("t4_c1_m0_gnt", 32'(bus.m0_gnt), 32'd1);
      step();
      bus.m0_req = 1'b0; bus.m1_req = 1'b1; bus.m1_addr = 32'h0000_00B0;
      bus.mem_rddata = 32'h1111_1111;
      @(negedge clk);
      check_val("t4_c2_m1_gnt",    32'(bus.m1_gnt),    32'd1);
      check_val("t4_c2_m0_rvalid", 32'(bus.m0_rvalid), 32'd1);
      check_val("t4_c2_m1_rvalid", 32'(bus.m1_rvalid), 32'd0);
      check_val("t4_c2_m0_rddata", bus.m0_rddata,      32'h1111_1111);
      step();
      bus.m1_req = 1'b0; bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h0000_00C0;
      bus.mem_rddata = 32'h2222_2222;
      @(negedge clk);
      check_val("t4_c3_mem_we",    32'(bus.mem_we),    32'd1);
      check_val("t4_c3_m1_rvalid", 32'(bus.m1_rvalid), 32'd1);
      check_val("t4_c3_m0_rvalid", 32'(bus.m0_rvalid), 32'd0);
      check_val("t4_c3_m1_rddata", bus.m1_rddata,      32'h2222_2222);
      step();
      clear_inputs();
      @(negedge clk);
      check_val("t4_c4_m0_rvalid", 32'(bus.m0_rvalid), 32'd0);
      check_val("t4_c4_m1_rvalid", 32'(bus.m1_rvalid), 32'd0);
      step();

      // 6: reset right after a granted locked M1 read
      bus.m1_req = 1'b1; bus.m1_lock = 1'b1; bus.m1_addr = 32'h0000_0F00;
      @(negedge clk);
      check_val("t6_m1_gnt", 32'(bus.m1_gnt), 32'd1);
      step();
      rst_n = 1'b0;
      bus.m0_req = 1'b1; bus.m0_we = 1'b1;
      @(negedge clk);
      check_val("t6_rst_m1_rvalid", 32'(bus.m1_rvalid), 32'd0);
      check_val("t6_rst_m1_gnt",    32'(bus.m1_gnt),    32'd0);
      check_val("t6_rst_m0_gnt",    32'(bus.m0_gnt),    32'd0);
      check_val("t6_rst_mem_we",    32'(bus.mem_we),    32'd0);
      check_val("t6_rst_owner",     32'(bus.arb_owner), 32'd0);
      step();
      rst_n = 1'b1;
      bus.m1_lock = 1'b0; bus.m1_we = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_val($sformatf("t6_owner[%0d]", i), 32'(bus.arb_owner), (i == 4) ? 32'd2 : 32'd1);
         check_val($sformatf("t6_m1_rvalid[%0d]", i), 32'(bus.m1_rvalid), 32'd0);
         step();
      end
      clear_inputs();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
